// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap/interrupt sequencer.
// Also holds the fetch-redirect target helper.
package trap_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_COMMIT   = 2'd2;
    localparam logic [1:0] ST_REDIRECT = 2'd3;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_MRET = 2'd1,
        KIND_IRQ  = 2'd2
    } trap_kind_e;

    localparam logic [3:0] CAUSE_EXT = 4'd11;
    localparam logic [3:0] CAUSE_SW  = 4'd3;
    localparam logic [3:0] CAUSE_TMR = 4'd7;
    localparam logic       MCAUSE_IRQ = 1'b1;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Vectored mode only applies to interrupts; the add wraps silently at 32 bits.
    function automatic logic [31:0] trap_target(input trap_kind_e kind, input logic [3:0] cause,
                                                input logic [31:0] mtvec, input logic [31:0] mepc);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (kind == KIND_MRET)
            return mepc;
        else if (kind == KIND_IRQ && mtvec[1:0] == 2'b01)
            return base + {26'd0, cause, 2'b00};
        else
            return base;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-file trap port plus fetch redirect handshake seen by the trap sequencer.
interface trap_ctrl_if;
    logic [2:0]  ctrl_mxip;
    logic        ctrl_mie;
    logic [2:0]  ctrl_mxie;
    logic        ctrl_trap;
    logic        ctrl_mret;
    logic [31:0] trap_pc;
    logic [4:0]  trap_info;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (
        output ctrl_mxip, ctrl_trap, ctrl_mret, trap_pc, trap_info, redirect_valid, redirect_pc,
        input  ctrl_mie, ctrl_mxie, csr_mtvec, csr_mepc, redirect_ready
    );

    modport slave (
        input  ctrl_mxip, ctrl_trap, ctrl_mret, trap_pc, trap_info, redirect_valid, redirect_pc,
        output ctrl_mie, ctrl_mxie, csr_mtvec, csr_mepc, redirect_ready
    );
endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Flop chain that brings raw interrupt levels into the controller clock domain.
module irq_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (srst) q <= '0;
                    else      q <= d_i;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (srst) q <= '0;
                    else      q <= g_stage[gi-1].q;
                end
            end
        end
    endgenerate

    assign q_o = g_stage[STAGES-1].q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: arbitrates exception, mret and interrupts, drains the
// pipeline, pulses the CSR commit, then holds a fetch redirect until accepted.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_tmr,
    input  logic        exc_req,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        mret_req,
    input  logic [31:0] cur_pc,
    input  logic        pipe_idle,
    output logic        trap_stall,
    trap_ctrl_if.master csr
);

    logic [1:0]  state_q, state_d;
    trap_kind_e  kind_q, kind_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rpc_q, rpc_d;

    logic [2:0]  mxip;
    logic [2:0]  pend;
    logic        irq_take;
    logic [3:0]  irq_cause;

    irq_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_irq_sync (
        .clk  (ctrl_clk),
        .srst (ctrl_reset),
        .d_i  ({irq_tmr, irq_sw, irq_ext}),
        .q_o  (mxip)
    );

    assign csr.ctrl_mxip = mxip;
    assign pend      = mxip & csr.ctrl_mxie;
    assign irq_take  = csr.ctrl_mie & (|pend);
    assign irq_cause = pend[0] ? CAUSE_EXT : (pend[1] ? CAUSE_SW : CAUSE_TMR);

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    kind_d  = KIND_EXC;
                    cause_d = exc_code;
                    pc_d    = exc_pc;
                    state_d = ST_DRAIN;
                end else if (mret_req) begin
                    kind_d  = KIND_MRET;
                    cause_d = 4'd0;
                    pc_d    = 32'd0;
                    state_d = ST_DRAIN;
                end else if (irq_take) begin
                    kind_d  = KIND_IRQ;
                    cause_d = irq_cause;
                    pc_d    = cur_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_idle) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                // Target is frozen here so it stays stable while fetch stalls the handshake.
                rpc_d   = trap_target(kind_q, cause_q, csr.csr_mtvec, csr.csr_mepc);
                state_d = ST_REDIRECT;
            end
            default: begin
                if (csr.redirect_ready) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_reset) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_EXC;
            cause_q <= 4'd0;
            pc_q    <= 32'd0;
            rpc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
        end
    end

    assign trap_stall         = (state_q != ST_IDLE);
    assign csr.ctrl_trap      = (state_q == ST_COMMIT);
    assign csr.ctrl_mret      = (state_q == ST_COMMIT) && (kind_q == KIND_MRET);
    assign csr.trap_pc        = (state_q == ST_COMMIT && kind_q != KIND_MRET) ? pc_q : 32'd0;
    assign csr.trap_info      = (state_q == ST_COMMIT && kind_q != KIND_MRET) ?
                                {kind_q == KIND_IRQ, cause_q} : 5'd0;
    assign csr.redirect_valid = (state_q == ST_REDIRECT);
    assign csr.redirect_pc    = (state_q == ST_REDIRECT) ? rpc_q : 32'd0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table, corner sequences and random traffic.
module tb_trap_ctrl;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_ext, irq_sw, irq_tmr;
    logic        exc_req, mret_req, pipe_idle;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc, cur_pc;
    logic        trap_stall;
    int          checks = 0;
    int          errors = 0;

    trap_ctrl_if bus();

    trap_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .ctrl_clk   (clk),
        .ctrl_reset (rst),
        .irq_ext    (irq_ext),
        .irq_sw     (irq_sw),
        .irq_tmr    (irq_tmr),
        .exc_req    (exc_req),
        .exc_code   (exc_code),
        .exc_pc     (exc_pc),
        .mret_req   (mret_req),
        .cur_pc     (cur_pc),
        .pipe_idle  (pipe_idle),
        .trap_stall (trap_stall),
        .csr        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;      // 0 exc, 1 mret, 2 irq
        logic [3:0]  code;
        logic [31:0] epc;
        logic [2:0]  lines;     // [0] ext, [1] sw, [2] tmr
        logic        mie;
        logic [2:0]  mxie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic [31:0] cpc;
        int          dw;
        int          rw;
        logic [4:0]  x_info;
        logic [31:0] x_tpc;
        logic [31:0] x_rpc;
        logic        x_mret;
    } vec_t;

    vec_t vt [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_lines(input logic [2:0] l);
        irq_ext = l[0];
        irq_sw  = l[1];
        irq_tmr = l[2];
    endtask

    task automatic settle();
        set_lines(3'b000);
        exc_req = 1'b0;
        mret_req = 1'b0;
        bus.ctrl_mie = 1'b0;
        repeat (SYNC + 2) tick();
    endtask

    // Plays the pipeline/fetch side of one trap and reports what the CSR port saw.
    task automatic do_txn(input int drain_wait, input int rdy_wait, input bit drop_mret,
                          output logic [4:0] info, output logic [31:0] tpc,
                          output logic [31:0] rpc, output logic mret, output int pulses);
        int n;
        pulses = 0; info = '0; tpc = '0; rpc = '0; mret = 1'b0;
        pipe_idle = (drain_wait == 0);
        n = 0;
        while (trap_stall !== 1'b1 && n < 20) begin tick(); n++; end
        chk("stall_rise", {31'd0, trap_stall}, 32'd1);
        exc_req = 1'b0;
        if (drop_mret) mret_req = 1'b0;
        set_lines(3'b000);
        for (int i = 0; i < drain_wait; i++) begin
            chk("drain_hold", {30'd0, trap_stall, bus.ctrl_trap}, 32'd2);
            tick();
        end
        pipe_idle = 1'b1;
        n = 0;
        while (bus.ctrl_trap !== 1'b1 && n < 20) begin tick(); n++; end
        chk("commit_seen", {31'd0, bus.ctrl_trap}, 32'd1);
        if (bus.ctrl_trap === 1'b1) begin
            pulses = 1;
            info = bus.trap_info;
            tpc  = bus.trap_pc;
            mret = bus.ctrl_mret;
        end
        tick();
        if (bus.ctrl_trap === 1'b1) pulses++;
        chk("redir_valid", {30'd0, bus.redirect_valid, trap_stall}, 32'd3);
        rpc = bus.redirect_pc;
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            if (bus.ctrl_trap === 1'b1) pulses++;
            chk("redir_hold_pc", bus.redirect_pc, rpc);
            chk("redir_hold_v", {31'd0, bus.redirect_valid}, 32'd1);
        end
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        chk("stall_drop", {30'd0, trap_stall, bus.redirect_valid}, 32'd0);
    endtask

    task automatic check_txn(input string tag, input int idx, input logic [4:0] info,
                             input logic [31:0] tpc, input logic [31:0] rpc, input logic mret,
                             input int pulses, input logic [4:0] x_info, input logic [31:0] x_tpc,
                             input logic [31:0] x_rpc, input logic x_mret);
        $display("%s %0d: info=0x%02h tpc=0x%08h rpc=0x%08h mret=%0d pulses=%0d",
                 tag, idx, info, tpc, rpc, mret, pulses);
        chk({tag, "_info"}, {27'd0, info}, {27'd0, x_info});
        chk({tag, "_tpc"}, tpc, x_tpc);
        chk({tag, "_rpc"}, rpc, x_rpc);
        chk({tag, "_mret"}, {31'd0, mret}, {31'd0, x_mret});
        chk({tag, "_pulses"}, pulses, 32'd1);
    endtask

    // Reference: arbitration and target address straight from the architectural rules.
    function automatic void ref_model(input bit exc, input bit mr, input logic [2:0] lines,
                                      input logic mie, input logic [2:0] mxie, input logic [3:0] code,
                                      input logic [31:0] epc, input logic [31:0] cpc,
                                      input logic [31:0] mtvec, input logic [31:0] mepc,
                                      output bit taken, output logic [4:0] info,
                                      output logic [31:0] tpc, output logic [31:0] rpc,
                                      output logic is_mret);
        logic [2:0] p;
        int cause;
        logic [31:0] base;
        p = lines & mxie;
        base = mtvec & 32'hFFFF_FFFC;
        taken = 1; info = 0; tpc = 0; rpc = 0; is_mret = 0;
        if (exc) begin
            info = {1'b0, code}; tpc = epc; rpc = base;
        end else if (mr) begin
            is_mret = 1; rpc = mepc;
        end else if (mie && p != 0) begin
            cause = p[0] ? 11 : (p[1] ? 3 : 7);
            info = 5'(16 + cause);
            tpc = cpc;
            rpc = (mtvec[1:0] == 2'b01) ? base + 32'(4 * cause) : base;
        end else begin
            taken = 0;
        end
    endfunction

    initial begin
        logic [4:0]  info, r_info;
        logic [31:0] tpc, rpc, r_tpc, r_rpc;
        logic        mret, r_mret;
        int          pulses, stall_seen;
        bit          taken, r_exc, r_mr;
        logic [2:0]  r_lines, r_mxie;
        logic        r_mie;

        vt[0] = '{0, 4'h2, 32'h100, 3'b000, 1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 0, 0,
                  5'h02, 32'h100, 32'h400, 1'b0};
        vt[1] = '{2, 4'h0, 32'h0, 3'b100, 1'b1, 3'b100, 32'h401, 32'h0, 32'h200, 5, 1,
                  5'h17, 32'h200, 32'h41C, 1'b0};
        vt[2] = '{2, 4'h0, 32'h0, 3'b111, 1'b1, 3'b111, 32'h401, 32'h0, 32'h300, 0, 2,
                  5'h1B, 32'h300, 32'h42C, 1'b0};
        vt[3] = '{1, 4'h0, 32'h0, 3'b000, 1'b0, 3'b000, 32'h400, 32'h804, 32'h0, 0, 0,
                  5'h00, 32'h0, 32'h804, 1'b1};
        vt[4] = '{2, 4'h0, 32'h0, 3'b010, 1'b1, 3'b111, 32'h1001, 32'h0, 32'h40, 1, 0,
                  5'h13, 32'h40, 32'h100C, 1'b0};
        vt[5] = '{0, 4'hB, 32'hFFFF_FFFC, 3'b000, 1'b0, 3'b000, 32'h801, 32'h0, 32'h0, 2, 1,
                  5'h0B, 32'hFFFF_FFFC, 32'h800, 1'b0};
        vt[6] = '{2, 4'h0, 32'h0, 3'b001, 1'b1, 3'b001, 32'hFFFF_FFFD, 32'h0, 32'h10, 0, 0,
                  5'h1B, 32'h10, 32'h28, 1'b0};
        vt[7] = '{2, 4'h0, 32'h0, 3'b111, 1'b1, 3'b110, 32'h500, 32'h0, 32'h60, 0, 0,
                  5'h13, 32'h60, 32'h500, 1'b0};

        rst = 1'b1;
        set_lines(3'b000);
        exc_req = 0; mret_req = 0; pipe_idle = 1; exc_code = 0; exc_pc = 0; cur_pc = 0;
        bus.ctrl_mie = 0; bus.ctrl_mxie = 0; bus.csr_mtvec = 0; bus.csr_mepc = 0;
        bus.redirect_ready = 0;
        tick(); tick();
        chk("reset_ctl", {26'd0, trap_stall, bus.ctrl_trap, bus.ctrl_mret, bus.redirect_valid,
                          bus.ctrl_mxip == 3'b000, 1'b0}, 32'd2);
        chk("reset_bus", bus.trap_pc | bus.redirect_pc | {27'd0, bus.trap_info}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus.csr_mtvec = vt[i].mtvec;
            bus.csr_mepc  = vt[i].mepc;
            bus.ctrl_mie  = vt[i].mie;
            bus.ctrl_mxie = vt[i].mxie;
            cur_pc = vt[i].cpc;
            exc_code = vt[i].code;
            exc_pc = vt[i].epc;
            set_lines(vt[i].lines);
            exc_req  = (vt[i].kind == 0);
            mret_req = (vt[i].kind == 1);
            do_txn(vt[i].dw, vt[i].rw, 1'b1, info, tpc, rpc, mret, pulses);
            check_txn("vec", i, info, tpc, rpc, mret, pulses,
                      vt[i].x_info, vt[i].x_tpc, vt[i].x_rpc, vt[i].x_mret);
            settle();
        end

        // Sync latency and global interrupt enable gating.
        bus.ctrl_mxie = 3'b111;
        bus.ctrl_mie = 1'b0;
        set_lines(3'b111);
        tick();
        chk("mxip_lat1", {29'd0, bus.ctrl_mxip}, 32'd0);
        tick();
        chk("mxip_lat2", {29'd0, bus.ctrl_mxip}, 32'd7);
        stall_seen = 0;
        repeat (10) begin tick(); if (trap_stall) stall_seen++; end
        $display("mie0: stall cycles=%0d", stall_seen);
        chk("mie0_no_stall", stall_seen, 32'd0);
        settle();

        // Exception, mret and interrupt together: exception first, mret after.
        bus.csr_mtvec = 32'h601; bus.csr_mepc = 32'h900;
        bus.ctrl_mie = 1'b1; bus.ctrl_mxie = 3'b111;
        set_lines(3'b111);
        repeat (SYNC) tick();
        exc_code = 4'h0; exc_pc = 32'h50; cur_pc = 32'h70;
        exc_req = 1'b1; mret_req = 1'b1;
        do_txn(0, 0, 1'b0, info, tpc, rpc, mret, pulses);
        check_txn("race_exc", 0, info, tpc, rpc, mret, pulses, 5'h00, 32'h50, 32'h600, 1'b0);
        do_txn(0, 0, 1'b1, info, tpc, rpc, mret, pulses);
        check_txn("race_mret", 1, info, tpc, rpc, mret, pulses, 5'h00, 32'h0, 32'h900, 1'b1);
        settle();

        // Reset while draining abandons the trap.
        exc_code = 4'h5; exc_pc = 32'h123; exc_req = 1'b1; pipe_idle = 1'b0;
        tick(); tick();
        chk("pre_rst_stall", {31'd0, trap_stall}, 32'd1);
        rst = 1'b1; exc_req = 1'b0; pipe_idle = 1'b1;
        tick();
        chk("rst_drain_ctl", {28'd0, trap_stall, bus.ctrl_trap, bus.ctrl_mret, bus.redirect_valid}, 32'd0);
        chk("rst_drain_bus", bus.trap_pc | bus.redirect_pc | {27'd0, bus.trap_info}, 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        repeat (6) begin tick(); if (bus.ctrl_trap || trap_stall) pulses++; end
        $display("rst_drain: activity cycles after reset=%0d", pulses);
        chk("rst_drain_quiet", pulses, 32'd0);

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            r_exc   = ($urandom_range(0, 2) == 0);
            r_mr    = ($urandom_range(0, 2) == 0);
            r_lines = 3'($urandom);
            r_mie   = ($urandom_range(0, 3) != 0);
            r_mxie  = 3'($urandom);
            bus.csr_mtvec = {$urandom() & 32'hFFFF_FFFC} | 32'($urandom_range(0, 2));
            bus.csr_mepc  = $urandom();
            cur_pc   = $urandom();
            exc_pc   = $urandom();
            exc_code = 4'($urandom);
            bus.ctrl_mie = r_mie; bus.ctrl_mxie = r_mxie;
            ref_model(r_exc, r_mr, r_lines, r_mie, r_mxie, exc_code, exc_pc, cur_pc,
                      bus.csr_mtvec, bus.csr_mepc, taken, r_info, r_tpc, r_rpc, r_mret);
            set_lines(r_lines);
            repeat (SYNC) tick();
            exc_req = r_exc; mret_req = r_mr;
            if (taken) begin
                do_txn($urandom_range(0, 3), $urandom_range(0, 2), 1'b1, info, tpc, rpc, mret, pulses);
                check_txn("rnd", t, info, tpc, rpc, mret, pulses, r_info, r_tpc, r_rpc, r_mret);
            end else begin
                stall_seen = 0;
                repeat (SYNC + 4) begin tick(); if (trap_stall) stall_seen++; end
                $display("rnd %0d: no request expected, stall cycles=%0d", t, stall_seen);
                chk("rnd_idle", stall_seen, 32'd0);
            end
            settle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
